// File: rtl/watch_pkg.sv
// Shared encodings and field widths for the multi-alarm watch.
package watch_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  typedef enum logic [1:0] {
    ModeRun      = 2'b00,
    ModeTimeSet  = 2'b01,
    ModeAlarmSet = 2'b10,
    ModeRunAlt   = 2'b11
  } mode_e;

  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
    return (m == MIN_W'(59)) ? '0 : m + 1'b1;
  endfunction

  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(23)) ? '0 : h + 1'b1;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: alarm time, snooze target, ring flag and ring-duration counter.
module alarm_slot
  import watch_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_run,
  input  logic              i_tick,
  input  logic              i_snooze,
  input  logic              i_min_inc,
  input  logic              i_hour_inc,
  input  logic [HOUR_W-1:0] i_cur_hour,
  input  logic [MIN_W-1:0]  i_cur_min,
  input  logic [HOUR_W-1:0] i_nx_hour,
  input  logic [MIN_W-1:0]  i_nx_min,
  input  logic [SEC_W-1:0]  i_nx_sec,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MIN_W-1:0]  o_min,
  output logic              o_ring
);

  localparam int unsigned CntW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  logic [HOUR_W-1:0] r_hour, w_hour_nx, r_tgt_hour, w_tgt_hour_nx;
  logic [MIN_W-1:0]  r_min, w_min_nx, r_tgt_min, w_tgt_min_nx;
  logic              r_tgt_v, w_tgt_v_nx, r_ring, w_ring_nx;
  logic [CntW-1:0]   r_cnt, w_cnt_nx;
  logic [MIN_W:0]    w_snz_sum;
  logic              w_alarm_hit, w_snz_hit;

  assign w_snz_sum   = {1'b0, i_cur_min} + (MIN_W + 1)'(SNOOZE_MIN);
  assign w_alarm_hit = i_tick && (i_nx_sec == '0) && (i_nx_hour == r_hour) && (i_nx_min == r_min);
  assign w_snz_hit   = i_tick && r_tgt_v && (i_nx_sec == '0) &&
                       (i_nx_hour == r_tgt_hour) && (i_nx_min == r_tgt_min);

  always_comb begin
    w_hour_nx     = i_hour_inc ? inc_hour(r_hour) : r_hour;
    w_min_nx      = i_min_inc ? inc_min(r_min) : r_min;
    w_tgt_hour_nx = r_tgt_hour;
    w_tgt_min_nx  = r_tgt_min;
    w_tgt_v_nx    = r_tgt_v;
    w_ring_nx     = r_ring;
    w_cnt_nx      = r_cnt;
    if (!i_en || i_min_inc || i_hour_inc) w_tgt_v_nx = 1'b0;
    if (!i_en || !i_run) begin
      w_ring_nx = 1'b0;
      w_cnt_nx  = '0;
    end else begin
      if (r_ring && i_snooze) begin
        w_ring_nx  = 1'b0;
        w_cnt_nx   = '0;
        w_tgt_v_nx = 1'b1;
        if (w_snz_sum >= (MIN_W + 1)'(60)) begin
          w_tgt_min_nx  = MIN_W'(w_snz_sum - (MIN_W + 1)'(60));
          w_tgt_hour_nx = inc_hour(i_cur_hour);
        end else begin
          w_tgt_min_nx  = MIN_W'(w_snz_sum);
          w_tgt_hour_nx = i_cur_hour;
        end
      end else if (r_ring && i_tick) begin
        // The starting tick leaves the counter at 0, so RING_SEC ticks later it reads RING_SEC-1.
        if (r_cnt == CntW'(RING_SEC - 1)) begin
          w_ring_nx = 1'b0;
          w_cnt_nx  = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      if (w_alarm_hit || w_snz_hit) begin
        w_ring_nx = 1'b1;
        w_cnt_nx  = '0;
        if (w_snz_hit) w_tgt_v_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hour     <= '0;
      r_min      <= '0;
      r_tgt_hour <= '0;
      r_tgt_min  <= '0;
      r_tgt_v    <= 1'b0;
      r_ring     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_hour     <= w_hour_nx;
      r_min      <= w_min_nx;
      r_tgt_hour <= w_tgt_hour_nx;
      r_tgt_min  <= w_tgt_min_nx;
      r_tgt_v    <= w_tgt_v_nx;
      r_ring     <= w_ring_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  assign o_hour = r_hour;
  assign o_min  = r_min;
  assign o_ring = r_ring;

endmodule

// File: rtl/multi_alarm_watch.sv
// 24-hour clock with settable time, N independent alarm slots, snooze and 12/24h display.
module multi_alarm_watch
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  localparam int unsigned SelW      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_mode,
  input  logic [SelW-1:0]     i_alarm_sel,
  input  logic [N_ALARMS-1:0] i_alarm_en,
  input  logic                i_minute_inc,
  input  logic                i_hour_inc,
  input  logic                i_snooze,
  input  logic                i_hour_12,
  output logic [HOUR_W-1:0]   o_disp_hour,
  output logic [MIN_W-1:0]    o_disp_minute,
  output logic [SEC_W-1:0]    o_disp_second,
  output logic                o_pm,
  output logic [N_ALARMS-1:0] o_alarm_ring,
  output logic                o_tick_1hz
);

  localparam int unsigned PresW = $clog2(CLK_HZ);

  logic [PresW-1:0]  r_presc;
  logic [HOUR_W-1:0] r_hour, w_nx_hour, w_src_hour, w_disp_hour;
  logic [MIN_W-1:0]  r_min, w_nx_min, w_src_min;
  logic [SEC_W-1:0]  r_sec, w_nx_sec, w_src_sec;
  logic              w_tset, w_aset, w_run, w_tick, w_sel_ok;
  mode_e             w_mode;
  logic [HOUR_W-1:0] w_slot_hour [N_ALARMS];
  logic [MIN_W-1:0]  w_slot_min  [N_ALARMS];

  assign w_mode   = mode_e'(i_mode);
  assign w_tset   = (w_mode == ModeTimeSet);
  assign w_aset   = (w_mode == ModeAlarmSet);
  assign w_run    = !w_tset && !w_aset;
  assign w_tick   = (r_presc == PresW'(CLK_HZ - 1)) && !w_tset;
  assign w_sel_ok = w_aset && (int'(i_alarm_sel) < int'(N_ALARMS));

  // Successor of the current time, applied only on a tick.
  always_comb begin
    w_nx_hour = r_hour;
    w_nx_min  = r_min;
    w_nx_sec  = r_sec + 1'b1;
    if (r_sec == SEC_W'(59)) begin
      w_nx_sec = '0;
      w_nx_min = inc_min(r_min);
      if (r_min == MIN_W'(59)) w_nx_hour = inc_hour(r_hour);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
    end else if (w_tset) begin
      r_presc <= '0;
      r_sec   <= '0;
      if (i_minute_inc) r_min <= inc_min(r_min);
      if (i_hour_inc) r_hour <= inc_hour(r_hour);
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_hour <= w_nx_hour;
        r_min  <= w_nx_min;
        r_sec  <= w_nx_sec;
      end
    end
  end

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_slot
    alarm_slot #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_SEC  (RING_SEC)
    ) u_slot (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_alarm_en[g]),
      .i_run     (w_run),
      .i_tick    (w_tick),
      .i_snooze  (i_snooze),
      .i_min_inc (w_sel_ok && (i_alarm_sel == SelW'(g)) && i_minute_inc),
      .i_hour_inc(w_sel_ok && (i_alarm_sel == SelW'(g)) && i_hour_inc),
      .i_cur_hour(r_hour),
      .i_cur_min (r_min),
      .i_nx_hour (w_nx_hour),
      .i_nx_min  (w_nx_min),
      .i_nx_sec  (w_nx_sec),
      .o_hour    (w_slot_hour[g]),
      .o_min     (w_slot_min[g]),
      .o_ring    (o_alarm_ring[g])
    );
  end

  always_comb begin
    w_src_hour = r_hour;
    w_src_min  = r_min;
    w_src_sec  = r_sec;
    if (w_aset) begin
      w_src_hour = '0;
      w_src_min  = '0;
      w_src_sec  = '0;
      if (w_sel_ok) begin
        w_src_hour = w_slot_hour[i_alarm_sel];
        w_src_min  = w_slot_min[i_alarm_sel];
      end
    end
    w_disp_hour = w_src_hour;
    if (i_hour_12) begin
      if (w_src_hour == '0) w_disp_hour = HOUR_W'(12);
      else if (w_src_hour > HOUR_W'(12)) w_disp_hour = w_src_hour - HOUR_W'(12);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_disp_hour   <= '0;
      o_disp_minute <= '0;
      o_disp_second <= '0;
      o_pm          <= 1'b0;
    end else begin
      o_disp_hour   <= w_disp_hour;
      o_disp_minute <= w_src_min;
      o_disp_second <= w_src_sec;
      o_pm          <= (w_src_hour >= HOUR_W'(12));
    end
  end

  assign o_tick_1hz = w_tick;

endmodule
